// File: rtl/cla_mul_seq.sv
// Shift-add 32x32 multiplier that borrows the ALU's shared carry-lookahead adder, one add per cycle.
// Define CLA_MUL_SIGNED_EN to add req_signed and the abs/negate steps around the unsigned core.
module cla_mul_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [0:WIDTH-1]     req_a,
  input  logic [0:WIDTH-1]     req_b,
`ifdef CLA_MUL_SIGNED_EN
  input  logic                 req_signed,
`endif
  input  logic                 flush,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [0:2*WIDTH-1]   rsp_prod,
  output logic                 busy,
  output logic [0:WIDTH-1]     add_a,
  output logic [0:WIDTH-1]     add_b,
  output logic                 add_cin,
  input  logic [0:WIDTH-1]     add_sum,
  input  logic                 add_cout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DONE   = 3'd2,
    S_ABS_A  = 3'd3,
    S_ABS_B  = 3'd4,
    S_NEG_LO = 3'd5,
    S_NEG_HI = 3'd6
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

  state_t               r_state;
  logic [0:WIDTH-1]     r_mcand;
  logic [0:WIDTH-1]     r_hi;
  logic [0:WIDTH-1]     r_lo;
  logic [5:0]           r_cnt;

  state_t               w_state_dp;
  state_t               w_state_nxt;
  logic [0:WIDTH-1]     w_mcand_nxt;
  logic [0:WIDTH-1]     w_hi_nxt;
  logic [0:WIDTH-1]     w_lo_nxt;
  logic [5:0]           w_cnt_nxt;
  logic                 w_req_ready;
  logic                 w_rsp_valid;
  logic                 w_busy;
  logic [0:WIDTH-1]     w_add_a;
  logic [0:WIDTH-1]     w_add_b;
  logic                 w_add_cin;
  logic [0:2*WIDTH-1]   w_prod;

`ifdef CLA_MUL_SIGNED_EN
  logic                 r_sgn;
  logic                 r_neg;
  logic                 r_carry;
  logic                 w_sgn_nxt;
  logic                 w_neg_nxt;
  logic                 w_carry_nxt;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= 6'd0;
`ifdef CLA_MUL_SIGNED_EN
      r_sgn   <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_mcand <= w_mcand_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef CLA_MUL_SIGNED_EN
      r_sgn   <= w_sgn_nxt;
      r_neg   <= w_neg_nxt;
      r_carry <= w_carry_nxt;
`endif
    end
  end

  // Next-state, datapath update and adder/handshake drive per state.
  always_comb begin
    w_state_dp  = r_state;
    w_mcand_nxt = r_mcand;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_cnt_nxt   = r_cnt;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b0;
    w_add_a     = '0;
    w_add_b     = '0;
    w_add_cin   = 1'b0;
    w_prod      = '0;
`ifdef CLA_MUL_SIGNED_EN
    w_sgn_nxt   = r_sgn;
    w_neg_nxt   = r_neg;
    w_carry_nxt = r_carry;
`endif
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid && !flush) begin
          w_mcand_nxt = req_a;
          w_lo_nxt    = req_b;
          w_hi_nxt    = '0;
          w_cnt_nxt   = 6'd0;
`ifdef CLA_MUL_SIGNED_EN
          w_sgn_nxt   = req_signed;
          w_neg_nxt   = req_signed & (req_a[0] ^ req_b[0]);
          w_state_dp  = S_ABS_A;
`else
          w_state_dp  = S_RUN;
`endif
        end else begin
          w_state_dp  = S_IDLE;
        end
      end
      S_RUN: begin
        w_busy    = 1'b1;
        w_add_a   = r_hi;
        w_add_b   = r_lo[WIDTH-1] ? r_mcand : '0;
        // 33-bit sum shifts right into hi; its LSB enters lo from the top.
        w_hi_nxt  = {add_cout, add_sum[0:WIDTH-2]};
        w_lo_nxt  = {add_sum[WIDTH-1], r_lo[0:WIDTH-2]};
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == CNT_LAST) begin
`ifdef CLA_MUL_SIGNED_EN
          w_state_dp = S_NEG_LO;
`else
          w_state_dp = S_DONE;
`endif
        end else begin
          w_state_dp = S_RUN;
        end
      end
      S_DONE: begin
        w_rsp_valid = 1'b1;
        w_prod      = {r_hi, r_lo};
        if (rsp_ready) begin
          w_state_dp = S_IDLE;
        end else begin
          w_state_dp = S_DONE;
        end
      end
`ifdef CLA_MUL_SIGNED_EN
      S_ABS_A: begin
        w_busy     = 1'b1;
        w_add_a    = ~r_mcand;
        w_add_cin  = 1'b1;
        w_state_dp = S_ABS_B;
        if (r_sgn && r_mcand[0]) begin
          w_mcand_nxt = add_sum;
        end else begin
          w_mcand_nxt = r_mcand;
        end
      end
      S_ABS_B: begin
        w_busy     = 1'b1;
        w_add_a    = ~r_lo;
        w_add_cin  = 1'b1;
        w_state_dp = S_RUN;
        if (r_sgn && r_lo[0]) begin
          w_lo_nxt = add_sum;
        end else begin
          w_lo_nxt = r_lo;
        end
      end
      S_NEG_LO: begin
        // Low-word carry is kept for the high-word negate next cycle.
        w_busy      = 1'b1;
        w_add_a     = ~r_lo;
        w_add_cin   = 1'b1;
        w_carry_nxt = add_cout;
        w_state_dp  = S_NEG_HI;
        if (r_neg) begin
          w_lo_nxt = add_sum;
        end else begin
          w_lo_nxt = r_lo;
        end
      end
      S_NEG_HI: begin
        w_busy     = 1'b1;
        w_add_a    = ~r_hi;
        w_add_cin  = r_carry;
        w_state_dp = S_DONE;
        if (r_neg) begin
          w_hi_nxt = add_sum;
        end else begin
          w_hi_nxt = r_hi;
        end
      end
`endif
      default: begin
        w_state_dp = S_IDLE;
      end
    endcase
    w_state_nxt = flush ? S_IDLE : w_state_dp;
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_prod  = w_prod;
  assign busy      = w_busy;
  assign add_a     = w_add_a;
  assign add_b     = w_add_b;
  assign add_cin   = w_add_cin;

endmodule
